// File: rtl/dma_pkg.sv
// Shared TileLink opcodes, beat geometry and FSM state type for the single-channel DMA copy engine.
package dma_pkg;

  localparam logic [2:0] TlGet           = 3'd4;
  localparam logic [2:0] TlPutFullData   = 3'd0;
  localparam logic [2:0] TlAccessAck     = 3'd0;
  localparam logic [2:0] TlAccessAckData = 3'd1;

  localparam logic [2:0]  BeatSize  = 3'd4;
  localparam int unsigned BeatBytes = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdReq  = 3'd1,
    StRdResp = 3'd2,
    StWrReq  = 3'd3,
    StWrResp = 3'd4
  } dma_state_e;

  function automatic logic beat_aligned(input logic [3:0] lsbs);
    return (lsbs == 4'h0);
  endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// Single-channel memory-to-memory copy engine acting as a TileLink host:
// each 16-byte beat is a Get followed by a PutFullData, one transaction outstanding.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned AddrWidth   = 38,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned SourceWidth = 3,
  parameter int unsigned SinkWidth   = 4,
  parameter int unsigned LenWidth    = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   src_i,
  input  logic [AddrWidth-1:0]   dst_i,
  input  logic [LenWidth-1:0]    len_i,
  input  logic                   irq_clear_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   irq_o,
  output logic                   tl_a_valid_o,
  input  logic                   tl_a_ready_i,
  output logic [2:0]             tl_a_opcode_o,
  output logic [2:0]             tl_a_param_o,
  output logic [2:0]             tl_a_size_o,
  output logic [SourceWidth-1:0] tl_a_source_o,
  output logic [AddrWidth-1:0]   tl_a_address_o,
  output logic [15:0]            tl_a_mask_o,
  output logic                   tl_a_corrupt_o,
  output logic [DataWidth-1:0]   tl_a_data_o,
  input  logic                   tl_d_valid_i,
  output logic                   tl_d_ready_o,
  input  logic [2:0]             tl_d_opcode_i,
  input  logic [2:0]             tl_d_param_i,
  input  logic [2:0]             tl_d_size_i,
  input  logic [SourceWidth-1:0] tl_d_source_i,
  input  logic [SinkWidth-1:0]   tl_d_sink_i,
  input  logic                   tl_d_denied_i,
  input  logic                   tl_d_corrupt_i,
  input  logic [DataWidth-1:0]   tl_d_data_i,
  output logic                   tl_b_ready_o,
  output logic                   tl_c_valid_o,
  output logic                   tl_e_valid_o
);

  localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(BeatBytes);
  localparam logic [LenWidth-1:0]  LenStep  = LenWidth'(BeatBytes);

  dma_state_e           state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic [DataWidth-1:0] buf_q, buf_d;
  logic                 a_valid_q, a_valid_d;
  logic [2:0]           a_opcode_q, a_opcode_d;
  logic [AddrWidth-1:0] a_address_q, a_address_d;
  logic                 d_ready_q, d_ready_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
  logic                 a_fire_s;
  logic                 d_fire_s;
  logic                 unused_s;

  assign a_fire_s = a_valid_q & tl_a_ready_i;
  assign d_fire_s = d_ready_q & tl_d_valid_i;

  // D-channel metadata carries nothing this host needs with one transaction in flight.
  assign unused_s = ^{tl_d_opcode_i, tl_d_param_i, tl_d_size_i, tl_d_source_i, tl_d_sink_i};

  // Next-state logic for the copy FSM, datapath and sticky status flags.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_address_d = a_address_q;
    d_ready_d   = d_ready_q;

    // Clear first so that any set event later in this block takes priority.
    if (irq_clear_i) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      done_d  = done_q;
      error_d = error_q;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d   = src_i;
          dst_d   = dst_i;
          rem_d   = len_i;
          done_d  = 1'b0;
          error_d = 1'b0;
          if (!beat_aligned(src_i[3:0]) || !beat_aligned(dst_i[3:0]) ||
              !beat_aligned(len_i[3:0])) begin
            error_d = 1'b1;
          end else if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StRdReq;
            a_valid_d   = 1'b1;
            a_opcode_d  = TlGet;
            a_address_d = src_i;
          end
        end else begin
          state_d = StIdle;
        end
      end

      StRdReq: begin
        if (a_fire_s) begin
          state_d   = StRdResp;
          a_valid_d = 1'b0;
          d_ready_d = 1'b1;
        end else begin
          state_d = StRdReq;
        end
      end

      StRdResp: begin
        if (d_fire_s) begin
          buf_d     = tl_d_data_i;
          d_ready_d = 1'b0;
          if (tl_d_denied_i || tl_d_corrupt_i) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d     = StWrReq;
            a_valid_d   = 1'b1;
            a_opcode_d  = TlPutFullData;
            a_address_d = dst_q;
          end
        end else begin
          state_d = StRdResp;
        end
      end

      StWrReq: begin
        if (a_fire_s) begin
          state_d   = StWrResp;
          a_valid_d = 1'b0;
          d_ready_d = 1'b1;
        end else begin
          state_d = StWrReq;
        end
      end

      StWrResp: begin
        if (d_fire_s) begin
          d_ready_d = 1'b0;
          if (tl_d_denied_i) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            src_d = src_q + AddrStep;
            dst_d = dst_q + AddrStep;
            rem_d = rem_q - LenStep;
            if (rem_q == LenStep) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d     = StRdReq;
              a_valid_d   = 1'b1;
              a_opcode_d  = TlGet;
              a_address_d = src_q + AddrStep;
            end
          end
        end else begin
          state_d = StWrResp;
        end
      end

      default: begin
        state_d   = StIdle;
        a_valid_d = 1'b0;
        d_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
    irq_d  = done_d | error_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      buf_q       <= '0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= TlGet;
      a_address_q <= '0;
      d_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      buf_q       <= buf_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      d_ready_q   <= d_ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign irq_o          = irq_q;
  assign tl_a_valid_o   = a_valid_q;
  assign tl_a_opcode_o  = a_opcode_q;
  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = BeatSize;
  assign tl_a_source_o  = '0;
  assign tl_a_address_o = a_address_q;
  assign tl_a_mask_o    = 16'hFFFF;
  assign tl_a_corrupt_o = 1'b0;
  assign tl_a_data_o    = buf_q;
  assign tl_d_ready_o   = d_ready_q;
  assign tl_b_ready_o   = 1'b1;
  assign tl_c_valid_o   = 1'b0;
  assign tl_e_valid_o   = 1'b0;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed self-checking bench for dma_copy_engine with a single-outstanding TileLink slave model.
module tb_dma_copy_engine;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [37:0]  src_i;
  logic [37:0]  dst_i;
  logic [23:0]  len_i;
  logic         irq_clear_i;
  logic         busy_o, done_o, error_o, irq_o;
  logic         tl_a_valid_o;
  logic         tl_a_ready_i;
  logic [2:0]   tl_a_opcode_o, tl_a_param_o, tl_a_size_o;
  logic [2:0]   tl_a_source_o;
  logic [37:0]  tl_a_address_o;
  logic [15:0]  tl_a_mask_o;
  logic         tl_a_corrupt_o;
  logic [127:0] tl_a_data_o;
  logic         tl_d_valid_i;
  logic         tl_d_ready_o;
  logic [2:0]   tl_d_opcode_i;
  logic [2:0]   tl_d_param_i, tl_d_size_i;
  logic [2:0]   tl_d_source_i;
  logic [3:0]   tl_d_sink_i;
  logic         tl_d_denied_i, tl_d_corrupt_i;
  logic [127:0] tl_d_data_i;
  logic         tl_b_ready_o, tl_c_valid_o, tl_e_valid_o;

  int checks = 0;
  int errors = 0;

  // Slave configuration (written by the test sequence) and transaction log (written by the slave).
  bit           clr_req   = 1'b0;
  bit           stall_en  = 1'b0;
  bit           hold_puts = 1'b0;
  int           deny_get  = -1;
  logic [2:0]   log_op   [16];
  logic [37:0]  log_addr [16];
  logic [127:0] log_data [16];
  int           n_log    = 0;
  int           stab_bad = 0;
  int           stab_cnt = 0;

  dma_copy_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .irq_clear_i(irq_clear_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .irq_o(irq_o), .tl_a_valid_o(tl_a_valid_o), .tl_a_ready_i(tl_a_ready_i),
    .tl_a_opcode_o(tl_a_opcode_o), .tl_a_param_o(tl_a_param_o), .tl_a_size_o(tl_a_size_o),
    .tl_a_source_o(tl_a_source_o), .tl_a_address_o(tl_a_address_o), .tl_a_mask_o(tl_a_mask_o),
    .tl_a_corrupt_o(tl_a_corrupt_o), .tl_a_data_o(tl_a_data_o), .tl_d_valid_i(tl_d_valid_i),
    .tl_d_ready_o(tl_d_ready_o), .tl_d_opcode_i(tl_d_opcode_i), .tl_d_param_i(tl_d_param_i),
    .tl_d_size_i(tl_d_size_i), .tl_d_source_i(tl_d_source_i), .tl_d_sink_i(tl_d_sink_i),
    .tl_d_denied_i(tl_d_denied_i), .tl_d_corrupt_i(tl_d_corrupt_i), .tl_d_data_i(tl_d_data_i),
    .tl_b_ready_o(tl_b_ready_o), .tl_c_valid_o(tl_c_valid_o), .tl_e_valid_o(tl_e_valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] beat_data(input logic [37:0] a);
    return {a[31:0] ^ 32'h1111_1111, a[31:0] ^ 32'h2222_2222,
            a[31:0] ^ 32'h3333_3333, a[31:0] ^ 32'h4444_4444};
  endfunction

  // Memory slave: grants A at a negedge (fire on the next posedge), answers on D afterwards.
  initial begin : slave
    int          a_stall, d_wait, get_idx, cur_get;
    bit          pend, armed, d_seen, cur_is_get;
    logic [37:0] cur_addr;
    logic [2:0]  h_op;
    logic [37:0] h_addr;
    logic [127:0] h_data;
    a_stall = 0; d_wait = 0; get_idx = 0; cur_get = 0;
    pend = 1'b0; armed = 1'b0; d_seen = 1'b0; cur_is_get = 1'b0; cur_addr = 38'h0;
    h_op = 3'd0; h_addr = 38'h0; h_data = 128'h0;
    tl_a_ready_i = 1'b0; tl_d_valid_i = 1'b0; tl_d_opcode_i = 3'd0; tl_d_param_i = 3'd0;
    tl_d_size_i = 3'd4; tl_d_source_i = 3'd0; tl_d_sink_i = 4'd0;
    tl_d_denied_i = 1'b0; tl_d_corrupt_i = 1'b0; tl_d_data_i = 128'h0;
    forever begin
      @(negedge clk_i);
      if (clr_req) begin
        n_log = 0; get_idx = 0; pend = 1'b0; armed = 1'b0; d_seen = 1'b0;
        stab_bad = 0; stab_cnt = 0; a_stall = 0; d_wait = 0;
        tl_a_ready_i = 1'b0; tl_d_valid_i = 1'b0; tl_d_denied_i = 1'b0;
      end else begin
        if (tl_d_valid_i && d_seen) begin
          tl_d_valid_i = 1'b0; tl_d_denied_i = 1'b0; pend = 1'b0;
        end
        tl_a_ready_i = 1'b0;
        if (!pend && tl_a_valid_o) begin
          if (!armed) begin
            armed = 1'b1;
            a_stall = stall_en ? int'($urandom_range(5, 0)) : 0;
            h_op = tl_a_opcode_o; h_addr = tl_a_address_o; h_data = tl_a_data_o;
          end else if (h_op !== tl_a_opcode_o || h_addr !== tl_a_address_o ||
                       h_data !== tl_a_data_o) begin
            stab_bad++;
          end
          if (!(hold_puts && tl_a_opcode_o == 3'd0)) begin
            if (a_stall > 0) begin
              a_stall--; stab_cnt++;
            end else begin
              tl_a_ready_i = 1'b1;
              if (n_log < 16) begin
                log_op[n_log] = tl_a_opcode_o; log_addr[n_log] = tl_a_address_o;
                log_data[n_log] = tl_a_data_o; n_log++;
              end
              cur_is_get = (tl_a_opcode_o == 3'd4);
              cur_addr = tl_a_address_o;
              cur_get = get_idx;
              if (cur_is_get) get_idx++;
              pend = 1'b1; armed = 1'b0;
              d_wait = stall_en ? int'($urandom_range(5, 0)) : 0;
            end
          end
        end else if (pend && !tl_d_valid_i) begin
          if (d_wait > 0) begin
            d_wait--;
          end else begin
            tl_d_valid_i  = 1'b1;
            tl_d_opcode_i = cur_is_get ? 3'd1 : 3'd0;
            tl_d_data_i   = cur_is_get ? beat_data(cur_addr) : 128'h0;
            tl_d_denied_i = cur_is_get && (cur_get == deny_get);
          end
        end
        d_seen = tl_d_ready_o;
      end
    end
  end

  task automatic clear_slave();
    clr_req = 1'b1;
    repeat (2) @(negedge clk_i);
    clr_req = 1'b0;
  endtask

  task automatic pulse_start(input logic [37:0] s, input logic [37:0] d, input logic [23:0] l);
    src_i = s; dst_i = d; len_i = l; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
    checks++; if (tl_a_valid_o !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b want 0", tl_a_valid_o); end
    checks++; if (tl_d_ready_o !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b want 0", tl_d_ready_o); end
    checks++; if ({tl_b_ready_o, tl_c_valid_o, tl_e_valid_o} !== 3'b100) begin
      errors++; $display("FAIL reset_bce got %b want 100", {tl_b_ready_o, tl_c_valid_o, tl_e_valid_o});
    end
    checks++; if ({tl_a_size_o, tl_a_mask_o, tl_a_param_o, tl_a_corrupt_o} !== {3'd4, 16'hFFFF, 3'd0, 1'b0}) begin
      errors++; $display("FAIL reset_a_consts got size=%0d mask=%h", tl_a_size_o, tl_a_mask_o);
    end
    rst_i = 1'b0;
    clear_slave();
  endtask

  task automatic run_copy_and_check(input string tag, input bit stalls, input bit restart);
    bit ok;
    logic [37:0] ea;
    stall_en = stalls;
    clear_slave();
    pulse_start(38'h1000, 38'h2000, 24'h40);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy_start got %b want 1", tag, busy_o); end
    if (restart) begin
      repeat (5) @(negedge clk_i);
      pulse_start(38'h9000, 38'hA000, 24'h10);
    end
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout busy still %b", tag, busy_o); end
    checks++; if (n_log !== 8) begin errors++; $display("FAIL %s_count got %0d want 8", tag, n_log); end
    for (int i = 0; i < 8; i++) begin
      ea = (i % 2 == 0) ? 38'h1000 + 38'(16 * (i / 2)) : 38'h2000 + 38'(16 * (i / 2));
      checks++; if (log_op[i] !== ((i % 2 == 0) ? 3'd4 : 3'd0)) begin
        errors++; $display("FAIL %s_op[%0d] got %0d want %0d", tag, i, log_op[i], (i % 2 == 0) ? 4 : 0);
      end
      checks++; if (log_addr[i] !== ea) begin
        errors++; $display("FAIL %s_addr[%0d] got %h want %h", tag, i, log_addr[i], ea);
      end
      if (i % 2 == 1) begin
        checks++; if (log_data[i] !== beat_data(38'h1000 + 38'(16 * (i / 2)))) begin
          errors++; $display("FAIL %s_data[%0d] got %h want %h", tag, i, log_data[i],
                             beat_data(38'h1000 + 38'(16 * (i / 2))));
        end
      end
    end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", tag, done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL %s_error got %b want 0", tag, error_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL %s_irq got %b want 1", tag, irq_o); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL %s_a_stable got %0d changes want 0", tag, stab_bad); end
    if (stalls) begin
      checks++; if (stab_cnt == 0) begin errors++; $display("FAIL %s_stalls got %0d stall cycles want >0", tag, stab_cnt); end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_basic_copy();
    run_copy_and_check("basic", 1'b0, 1'b0);
  endtask

  task automatic test_stalled_copy();
    run_copy_and_check("stall", 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_copy_and_check("restart", 1'b0, 1'b1);
  endtask

  task automatic test_denied_read();
    bit ok;
    clear_slave();
    deny_get = 2;
    pulse_start(38'h1000, 38'h2000, 24'h30);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL deny_timeout busy still %b", busy_o); end
    checks++; if (n_log !== 5) begin errors++; $display("FAIL deny_count got %0d want 5", n_log); end
    checks++; if (log_op[4] !== 3'd4 || log_addr[4] !== 38'h1020) begin
      errors++; $display("FAIL deny_last got op=%0d addr=%h want op=4 addr=1020", log_op[4], log_addr[4]);
    end
    checks++; if (log_addr[3] !== 38'h2010) begin errors++; $display("FAIL deny_put2 got %h want 2010", log_addr[3]); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL deny_error got %b want 1", error_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL deny_done got %b want 0", done_o); end
    checks++; if (tl_d_ready_o !== 1'b0) begin errors++; $display("FAIL deny_d_ready got %b want 0", tl_d_ready_o); end
    deny_get = -1;
  endtask

  task automatic test_misaligned();
    clear_slave();
    pulse_start(38'h1008, 38'h2000, 24'h40);
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL misalign_error got %b want 1", error_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL misalign_busy got %b want 0", busy_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL misalign_irq got %b want 1", irq_o); end
    repeat (4) @(negedge clk_i);
    checks++; if (n_log !== 0) begin errors++; $display("FAIL misalign_traffic got %0d want 0", n_log); end
    irq_clear_i = 1'b1;
    @(negedge clk_i);
    irq_clear_i = 1'b0;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL clear_irq got %b want 0", irq_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL clear_error got %b want 0", error_o); end
    // set-versus-clear in the same cycle: the misaligned dst must still raise error
    irq_clear_i = 1'b1;
    pulse_start(38'h1000, 38'h2004, 24'h40);
    irq_clear_i = 1'b0;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL set_wins_error got %b want 1", error_o); end
    pulse_start(38'h1000, 38'h2000, 24'h48);
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL len_misalign got %b want 1", error_o); end
  endtask

  task automatic test_zero_length();
    clear_slave();
    pulse_start(38'h3000, 38'h4000, 24'h0);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zlen_done got %b want 1", done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL zlen_error got %b want 0", error_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zlen_busy got %b want 0", busy_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (n_log !== 0) begin errors++; $display("FAIL zlen_traffic got %0d want 0", n_log); end
  endtask

  task automatic test_reset_mid_copy();
    bit hit;
    hit = 1'b0;
    clear_slave();
    hold_puts = 1'b1;
    pulse_start(38'h1000, 38'h2000, 24'h40);
    for (int i = 0; i < 50; i++) begin
      if (tl_a_valid_o && tl_a_opcode_o == 3'd0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_wr got %b want 1", hit); end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (tl_a_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_a_valid got %b want 0", tl_a_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    checks++; if ({done_o, error_o} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b want 00", {done_o, error_o}); end
    rst_i = 1'b0;
    hold_puts = 1'b0;
    clear_slave();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; src_i = 38'h0; dst_i = 38'h0; len_i = 24'h0; irq_clear_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_basic_copy();
    test_stalled_copy();
    test_denied_read();
    test_misaligned();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
